// File: rtl/xif_copro_commit_queue.sv
`default_nettype none
// ============================================================================
// Module      : xif_copro_commit_queue
// Description : In-flight instruction queue for an XIF coprocessor. Entries
//               are accepted speculatively, wait for the core's commit/kill,
//               leave in order once committed and are dropped when killed.
//               Define XIF_COPRO_COMMIT_BYPASS_EN to let a commit of a SPEC
//               head entry present pop_valid_o in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module xif_copro_commit_queue #(
  parameter int DEPTH    = 4,
  parameter int ID_WIDTH = 4,
  parameter int NUM_RS   = 2,
  parameter int XLEN     = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic                       push_valid_i,
  output logic                       push_ready_o,
  input  logic [ID_WIDTH-1:0]        push_id_i,
  input  logic [31:0]                push_instr_i,
  input  logic [1:0]                 push_mode_i,
  input  logic [NUM_RS*XLEN-1:0]     push_rs_i,
  input  logic                       commit_valid_i,
  input  logic [ID_WIDTH-1:0]        commit_id_i,
  input  logic                       commit_kill_i,
  output logic                       pop_valid_o,
  input  logic                       pop_ready_i,
  output logic [ID_WIDTH-1:0]        pop_id_o,
  output logic [31:0]                pop_instr_o,
  output logic [1:0]                 pop_mode_o,
  output logic [NUM_RS*XLEN-1:0]     pop_rs_o,
  output logic                       killed_valid_o,
  output logic [ID_WIDTH-1:0]        killed_id_o,
  output logic [$clog2(DEPTH+1)-1:0] usage_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_CNT_W = $clog2(DEPTH + 1);
  localparam logic [c_PTR_W-1:0] c_LAST_PTR  = c_PTR_W'(DEPTH - 1);
  localparam logic [c_CNT_W-1:0] c_DEPTH_CNT = c_CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    ST_FREE      = 2'd0,
    ST_SPEC      = 2'd1,
    ST_COMMITTED = 2'd2,
    ST_KILLED    = 2'd3
  } entry_state_e;

  entry_state_e                r_state     [DEPTH];
  entry_state_e                w_state_nxt [DEPTH];
  entry_state_e                w_push_state;
  logic [ID_WIDTH-1:0]         r_id        [DEPTH];
  logic [31:0]                 r_instr     [DEPTH];
  logic [1:0]                  r_mode      [DEPTH];
  logic [NUM_RS*XLEN-1:0]      r_rs        [DEPTH];
  logic [c_PTR_W-1:0]          r_head;
  logic [c_PTR_W-1:0]          r_tail;
  logic [c_CNT_W-1:0]          r_usage;

  entry_state_e                w_head_state;
  logic [ID_WIDTH-1:0]         w_head_id;
  logic                        w_push_fire;
  logic                        w_pop_fire;
  logic                        w_kill_drop;
  logic                        w_release;
  logic                        w_bypass;

  function automatic logic [c_PTR_W-1:0] f_next_ptr(input logic [c_PTR_W-1:0] ptr);
    return (ptr == c_LAST_PTR) ? '0 : ptr + 1'b1;
  endfunction

  assign w_head_state = r_state[r_head];
  assign w_head_id    = r_id[r_head];

  // Ready comes from the registered count only: no push into a full queue,
  // even if the head leaves in the same cycle.
  assign push_ready_o = (r_usage < c_DEPTH_CNT);
  assign w_push_fire  = push_valid_i & push_ready_o;

`ifdef XIF_COPRO_COMMIT_BYPASS_EN
  // A plain commit hitting the SPEC head is presented immediately.
  assign w_bypass = commit_valid_i & ~commit_kill_i &
                    (w_head_state == ST_SPEC) & (w_head_id == commit_id_i);
`else
  assign w_bypass = 1'b0;
`endif

  assign pop_valid_o    = (w_head_state == ST_COMMITTED) | w_bypass;
  assign w_pop_fire     = pop_valid_o & pop_ready_i;
  // Killed heads drain one per cycle without a consumer handshake.
  assign w_kill_drop    = (w_head_state == ST_KILLED);
  assign w_release      = w_pop_fire | w_kill_drop;
  assign killed_valid_o = w_kill_drop;

  // Data outputs read zero unless the matching valid is up.
  assign pop_id_o    = pop_valid_o ? w_head_id        : '0;
  assign pop_instr_o = pop_valid_o ? r_instr[r_head]  : '0;
  assign pop_mode_o  = pop_valid_o ? r_mode[r_head]   : '0;
  assign pop_rs_o    = pop_valid_o ? r_rs[r_head]     : '0;
  assign killed_id_o = w_kill_drop ? w_head_id        : '0;

  assign usage_o = r_usage;
  assign full_o  = (r_usage == c_DEPTH_CNT);
  assign empty_o = (r_usage == '0);

  // Next state per entry: commit/kill match, then head release, then push write.
  always_comb begin
    w_push_state = ST_SPEC;
    if (commit_valid_i && (commit_id_i == push_id_i)) begin
      w_push_state = commit_kill_i ? ST_KILLED : ST_COMMITTED;
    end
    for (int i = 0; i < DEPTH; i++) begin
      w_state_nxt[i] = r_state[i];
      if (commit_valid_i && (r_state[i] == ST_SPEC) && (r_id[i] == commit_id_i)) begin
        w_state_nxt[i] = commit_kill_i ? ST_KILLED : ST_COMMITTED;
      end
      if (w_release && (c_PTR_W'(i) == r_head)) begin
        w_state_nxt[i] = ST_FREE;
      end
      if (w_push_fire && (c_PTR_W'(i) == r_tail)) begin
        w_state_nxt[i] = w_push_state;
      end
    end
  end

  // Entry state registers; flush clears everything ahead of any other update.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) r_state[i] <= ST_FREE;
    end else if (flush_i) begin
      for (int i = 0; i < DEPTH; i++) r_state[i] <= ST_FREE;
    end else begin
      for (int i = 0; i < DEPTH; i++) r_state[i] <= w_state_nxt[i];
    end
  end

  // Payload storage, qualified by entry state so it needs no reset.
  always_ff @(posedge clk_i) begin
    if (w_push_fire && !flush_i) begin
      r_id[r_tail]    <= push_id_i;
      r_instr[r_tail] <= push_instr_i;
      r_mode[r_tail]  <= push_mode_i;
      r_rs[r_tail]    <= push_rs_i;
    end
  end

  // Head/tail pointers and occupancy count.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_usage <= '0;
    end else if (flush_i) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_usage <= '0;
    end else begin
      if (w_push_fire) r_tail <= f_next_ptr(r_tail);
      if (w_release)   r_head <= f_next_ptr(r_head);
      if (w_push_fire && !w_release) begin
        r_usage <= r_usage + 1'b1;
      end else if (!w_push_fire && w_release) begin
        r_usage <= r_usage - 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_xif_copro_commit_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_xif_copro_commit_queue
// Description : Scoreboard bench for xif_copro_commit_queue: stimulus queues
//               the expected pop/kill events, a monitor retires them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_xif_copro_commit_queue;

  localparam int DEPTH  = 4;
  localparam int ID_W   = 4;
  localparam int NUM_RS = 2;
  localparam int XLEN   = 32;
`ifdef XIF_COPRO_COMMIT_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic                   clk;
  logic                   rst_n;
  logic                   flush;
  logic                   push_valid;
  logic                   push_ready;
  logic [ID_W-1:0]        push_id;
  logic [31:0]            push_instr;
  logic [1:0]             push_mode;
  logic [NUM_RS*XLEN-1:0] push_rs;
  logic                   commit_valid;
  logic [ID_W-1:0]        commit_id;
  logic                   commit_kill;
  logic                   pop_valid;
  logic                   pop_ready;
  logic [ID_W-1:0]        pop_id;
  logic [31:0]            pop_instr;
  logic [1:0]             pop_mode;
  logic [NUM_RS*XLEN-1:0] pop_rs;
  logic                   killed_valid;
  logic [ID_W-1:0]        killed_id;
  logic [2:0]             usage;
  logic                   full;
  logic                   empty;

  xif_copro_commit_queue #(
    .DEPTH(DEPTH), .ID_WIDTH(ID_W), .NUM_RS(NUM_RS), .XLEN(XLEN)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .push_valid_i(push_valid), .push_ready_o(push_ready), .push_id_i(push_id),
    .push_instr_i(push_instr), .push_mode_i(push_mode), .push_rs_i(push_rs),
    .commit_valid_i(commit_valid), .commit_id_i(commit_id), .commit_kill_i(commit_kill),
    .pop_valid_o(pop_valid), .pop_ready_i(pop_ready), .pop_id_o(pop_id),
    .pop_instr_o(pop_instr), .pop_mode_o(pop_mode), .pop_rs_o(pop_rs),
    .killed_valid_o(killed_valid), .killed_id_o(killed_id),
    .usage_o(usage), .full_o(full), .empty_o(empty)
  );

  typedef struct {
    bit              kill;
    logic [ID_W-1:0] id;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Payload patterns derived from the ID; ID 3 carries instr 0x0000_2007.
  function automatic logic [31:0] f_instr(input logic [ID_W-1:0] id);
    return 32'h0000_2007 + ({28'd0, id} * 32'h100) - 32'h300;
  endfunction

  function automatic logic [63:0] f_rs(input logic [ID_W-1:0] id);
    return {32'hB000_0000 | {28'd0, id}, 32'hA000_0000 | {28'd0, id}};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_push(input logic [ID_W-1:0] id);
    push_valid = 1'b1;
    push_id    = id;
    push_instr = f_instr(id);
    push_mode  = id[1:0];
    push_rs    = f_rs(id);
  endtask

  task automatic expect_ev(input bit kill, input logic [ID_W-1:0] id);
    exp_t e;
    e.kill = kill;
    e.id   = id;
    exp_q.push_back(e);
  endtask

  task automatic commit(input logic [ID_W-1:0] id, input logic kill);
    commit_valid = 1'b1;
    commit_id    = id;
    commit_kill  = kill;
  endtask

  // Monitor: retire every pop handshake and kill-drop against the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (pop_valid && pop_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pop: got id=%0d expected no event", pop_id);
        end else begin
          mon_e = exp_q.pop_front();
          chk("pop_kind", 64'(mon_e.kill), 64'd0);
          chk("pop_id", pop_id, mon_e.id);
          chk("pop_instr", pop_instr, f_instr(mon_e.id));
          chk("pop_mode", pop_mode, mon_e.id[1:0]);
          chk("pop_rs", pop_rs, f_rs(mon_e.id));
        end
      end
      if (killed_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_kill: got id=%0d expected no event", killed_id);
        end else begin
          mon_e = exp_q.pop_front();
          chk("kill_kind", 64'(mon_e.kill), 64'd1);
          chk("kill_id", killed_id, mon_e.id);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; push_valid = 1'b0; push_id = '0; push_instr = '0;
    push_mode = '0; push_rs = '0; commit_valid = 1'b0; commit_id = '0;
    commit_kill = 1'b0; pop_ready = 1'b0;

    // Reset values
    #12;
    chk("rst_empty", empty, 1'b1);
    chk("rst_full", full, 1'b0);
    chk("rst_push_ready", push_ready, 1'b1);
    chk("rst_pop_valid", pop_valid, 1'b0);
    chk("rst_killed_valid", killed_valid, 1'b0);
    chk("rst_usage", usage, 3'd0);
    chk("rst_pop_id", pop_id, 4'd0);
    chk("rst_pop_instr", pop_instr, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Basic push / commit / pop
    pop_ready = 1'b1;
    drive_push(4'd3); expect_ev(1'b0, 4'd3);
    step();
    push_valid = 1'b0; commit(4'd3, 1'b0);
    #1;
    chk("t1_pop_valid_commit_cycle", pop_valid, BYP);
    chk("t1_usage_one", usage, 3'd1);
    step();
    commit_valid = 1'b0;
    #1;
    chk("t1_pop_valid_after_commit", pop_valid, !BYP);
    chk("t1_pop_id", pop_id, BYP ? 4'd0 : 4'd3);
    step();
    chk("t1_usage_zero", usage, 3'd0);
    chk("t1_empty", empty, 1'b1);

    // Fill to DEPTH, reject the fifth push until an entry frees
    for (int i = 0; i < 4; i++) begin
      drive_push(4'(i)); expect_ev(1'b0, 4'(i));
      step();
    end
    drive_push(4'd4); expect_ev(1'b0, 4'd4);
    commit(4'd0, 1'b0);
    #1;
    chk("t2_full", full, 1'b1);
    chk("t2_push_ready_full", push_ready, 1'b0);
    chk("t2_usage_full", usage, 3'd4);
    step();
    commit_valid = 1'b0;
    #1;
    chk("t2_usage_after_commit", usage, BYP ? 3'd3 : 3'd4);
    chk("t2_push_ready_after_commit", push_ready, BYP);
    step();
    chk("t2_usage_after_free", usage, BYP ? 3'd4 : 3'd3);
    if (BYP) push_valid = 1'b0;
    step();
    push_valid = 1'b0;
    chk("t2_usage_refilled", usage, 3'd4);
    for (int i = 1; i < 5; i++) begin
      commit(4'(i), 1'b0);
      step();
    end
    commit_valid = 1'b0;
    repeat (3) step();
    chk("t2_drained_usage", usage, 3'd0);
    chk("t2_drained_empty", empty, 1'b1);

    // Out-of-order commits, kill of the head
    drive_push(4'd1); expect_ev(1'b1, 4'd1); step();
    drive_push(4'd2); expect_ev(1'b0, 4'd2); step();
    drive_push(4'd3); expect_ev(1'b0, 4'd3); step();
    push_valid = 1'b0;
    commit(4'd3, 1'b0); step();
    #1;
    chk("t3_head_blocks", pop_valid, 1'b0);
    commit(4'd2, 1'b0); step();
    commit(4'd1, 1'b1);
    #1;
    chk("t3_kill_not_same_cycle", killed_valid, 1'b0);
    step();
    commit_valid = 1'b0; commit_kill = 1'b0;
    #1;
    chk("t3_killed_valid", killed_valid, 1'b1);
    chk("t3_killed_id", killed_id, 4'd1);
    chk("t3_no_pop_on_kill", pop_valid, 1'b0);
    step();
    chk("t3_pop2_valid", pop_valid, 1'b1);
    chk("t3_pop2_id", pop_id, 4'd2);
    step();
    chk("t3_pop3_id", pop_id, 4'd3);
    step();
    chk("t3_empty", empty, 1'b1);

    // Push and commit of the same ID in one cycle
    drive_push(4'd5); expect_ev(1'b0, 4'd5);
    commit(4'd5, 1'b0);
    step();
    push_valid = 1'b0; commit_valid = 1'b0;
    #1;
    chk("t4_pop_valid_next", pop_valid, 1'b1);
    chk("t4_pop_id", pop_id, 4'd5);
    step();
    chk("t4_empty", empty, 1'b1);

`ifdef XIF_COPRO_COMMIT_BYPASS_EN
    drive_push(4'd12); expect_ev(1'b0, 4'd12);
    step();
    push_valid = 1'b0; commit(4'd12, 1'b0);
    #1;
    chk("t4b_bypass_pop_valid", pop_valid, 1'b1);
    chk("t4b_bypass_pop_id", pop_id, 4'd12);
    step();
    commit_valid = 1'b0;
    chk("t4b_empty", empty, 1'b1);
`endif

    // Flush with concurrent push and commit
    drive_push(4'd6); step();
    drive_push(4'd7); step();
    drive_push(4'd8); step();
    drive_push(4'd9); commit(4'd6, 1'b0); flush = 1'b1;
    #1;
    chk("t5_usage_before_flush", usage, 3'd3);
    step();
    flush = 1'b0; push_valid = 1'b0; commit_valid = 1'b0;
    #1;
    chk("t5_flush_usage", usage, 3'd0);
    chk("t5_flush_empty", empty, 1'b1);
    chk("t5_flush_push_ready", push_ready, 1'b1);
    repeat (4) step();
    chk("t5_no_pop", pop_valid, 1'b0);
    chk("t5_no_kill", killed_valid, 1'b0);

    // Asynchronous reset with committed entries in flight
    pop_ready = 1'b0;
    drive_push(4'd10); step();
    drive_push(4'd11); commit(4'd10, 1'b0); step();
    push_valid = 1'b0; commit(4'd11, 1'b0); step();
    commit_valid = 1'b0;
    #1;
    chk("t6_pop_valid_held", pop_valid, 1'b1);
    chk("t6_usage_two", usage, 3'd2);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_pop_valid", pop_valid, 1'b0);
    chk("t6_rst_usage", usage, 3'd0);
    chk("t6_rst_empty", empty, 1'b1);
    chk("t6_rst_full", full, 1'b0);
    chk("t6_rst_push_ready", push_ready, 1'b1);
    chk("t6_rst_pop_id", pop_id, 4'd0);
    chk("t6_rst_killed_valid", killed_valid, 1'b0);
    step();
    step();
    @(negedge clk);
    rst_n = 1'b1;
    pop_ready = 1'b1;
    repeat (4) step();
    chk("t6_no_pop_after_reset", pop_valid, 1'b0);
    chk("t6_usage_after_reset", usage, 3'd0);

    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
